// File: rtl/rp_ping_pkg.sv
// Shared definitions for the single-wire ping link controller: FSM state
// encoding and miss-counter width.
package rp_ping_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DRIVE,
        S_TURN,
        S_LISTEN
    } ping_state_t;

    localparam int MISS_W = 8;
    localparam logic [MISS_W-1:0] MISS_SAT = '1;

endpackage

// File: rtl/rp_iobuf.sv
// Bidirectional pad wrapper: tri-state output buffer plus a 2-flop
// synchroniser on the pad input.
module rp_iobuf (
    input  logic clk,
    input  logic rst,
    input  logic direction,
    input  logic val_out,
    inout  wire  val_tri,
    output logic val_sync
);

    logic meta;
    logic sync;

    // direction = 1 releases the pad; the output is enabled only when it is 0.
    assign val_tri = direction ? 1'bz : val_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= val_tri;
            sync <= meta;
        end
    end

    assign val_sync = sync;

endmodule

// File: rtl/rp_ping_link_ctrl.sv
// Single-wire ping link controller: periodically drives a pulse on a shared pad,
// listens for a rising-edge response and tracks consecutive misses.
module rp_ping_link_ctrl
    import rp_ping_pkg::*;
#(
    parameter int PULSE_LEN  = 16,
    parameter int TURNAROUND = 4,
    parameter int TIMEOUT    = 1024,
    parameter int MAX_MISS   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [31:0]       period,
    input  logic              alarm_clear,
    inout  wire               val_tri,
    output logic              busy,
    output logic              resp_valid,
    output logic [MISS_W-1:0] miss_count,
    output logic              alarm
);

    localparam logic [31:0] PULSE_LOAD  = 32'(PULSE_LEN - 1);
    localparam logic [31:0] TURN_LOAD   = 32'(TURNAROUND - 1);
    localparam logic [31:0] LISTEN_LOAD = 32'(TIMEOUT - 1);
    localparam logic [31:0] MAX_MISS_U  = 32'(MAX_MISS);

    ping_state_t       state;
    logic [31:0]       cnt;
    logic              direction;
    logic              val_out;
    logic              val_sync;
    logic              sync_d;
    logic              resp_edge;
    logic [31:0]       wait_load;
    logic [MISS_W-1:0] miss_next;
    logic              alarm_hit;

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (v == MISS_SAT) ? v : v + MISS_W'(1);
    endfunction

    rp_iobuf u_pad (
        .clk       (clk),
        .rst       (rst),
        .direction (direction),
        .val_out   (val_out),
        .val_tri   (val_tri),
        .val_sync  (val_sync)
    );

    // sync_d tracks the pad through TURN, so a line already high at LISTEN entry shows no edge.
    assign resp_edge = val_sync & ~sync_d;
    assign wait_load = (period == 32'd0) ? 32'd0 : period - 32'd1;
    assign miss_next = sat_inc(miss_count);
    assign alarm_hit = ({{(32-MISS_W){1'b0}}, miss_next} >= MAX_MISS_U);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            direction  <= 1'b1;
            val_out    <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            miss_count <= '0;
            alarm      <= 1'b0;
            sync_d     <= 1'b0;
        end else begin
            sync_d     <= val_sync;
            resp_valid <= 1'b0;
            if (alarm_clear) begin
                alarm      <= 1'b0;
                miss_count <= '0;
            end
            if (!enable) begin
                state     <= S_IDLE;
                cnt       <= '0;
                direction <= 1'b1;
                val_out   <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_WAIT;
                        cnt   <= wait_load;
                    end
                    S_WAIT: begin
                        if (cnt == '0) begin
                            state     <= S_DRIVE;
                            cnt       <= PULSE_LOAD;
                            direction <= 1'b0;
                            val_out   <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    S_DRIVE: begin
                        if (cnt == '0) begin
                            state     <= S_TURN;
                            cnt       <= TURN_LOAD;
                            direction <= 1'b1;
                            val_out   <= 1'b0;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    S_TURN: begin
                        if (cnt == '0) begin
                            state <= S_LISTEN;
                            cnt   <= LISTEN_LOAD;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    S_LISTEN: begin
                        // A response seen on the last LISTEN cycle beats the timeout.
                        if (resp_edge) begin
                            resp_valid <= 1'b1;
                            miss_count <= '0;
                            state      <= S_WAIT;
                            cnt        <= wait_load;
                            busy       <= 1'b0;
                        end else if (cnt == '0) begin
                            miss_count <= miss_next;
                            if (alarm_hit) alarm <= 1'b1;
                            state      <= S_WAIT;
                            cnt        <= wait_load;
                            busy       <= 1'b0;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        direction <= 1'b1;
                        val_out   <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rp_ping_link_ctrl.sv
// Self-checking bench for rp_ping_link_ctrl: directed and randomized ping
// cycles compared against a timing/counter model of the link protocol.
module tb_rp_ping_link_ctrl;

    localparam int PULSE_LEN  = 16;
    localparam int TURNAROUND = 4;
    localparam int TIMEOUT    = 40;
    localparam int MAX_MISS   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        alarm_clear = 1'b0;
    logic        drv = 1'b0;
    logic [31:0] period = 32'd0;
    wire         val_tri;
    logic        busy;
    logic        resp_valid;
    logic [7:0]  miss_count;
    logic        alarm;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int m_miss = 0;
    int m_alarm = 0;

    // Responder only ever pulls the line high; otherwise the line idles low.
    assign val_tri = drv ? 1'b1 : 1'bz;
    pulldown (val_tri);

    always #5 clk = ~clk;

    rp_ping_link_ctrl #(
        .PULSE_LEN  (PULSE_LEN),
        .TURNAROUND (TURNAROUND),
        .TIMEOUT    (TIMEOUT),
        .MAX_MISS   (MAX_MISS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .period      (period),
        .alarm_clear (alarm_clear),
        .val_tri     (val_tri),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .miss_count  (miss_count),
        .alarm       (alarm)
    );

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_drive();
        int g;
        g = 0;
        while (dut.direction !== 1'b0 && g < 4000) begin
            tick();
            g++;
        end
        chk_val("drive_seen", dut.direction, 0);
    endtask

    // One full ping cycle. k >= 0: responder raises the line k cycles into LISTEN.
    task automatic ping(input int exp_start, input int k, input bit hold, input bit clr_end,
                        input int next_period, output int next_start);
        int g, len, bad, l0, exp_end;
        bit hit;
        g = 0;
        while (dut.direction !== 1'b0 && g < 4000) begin
            tick();
            g++;
        end
        chk_val("drive_start", cyc, exp_start);
        chk_val("busy_drive", busy, 1);
        period = next_period;
        len = 0;
        bad = 0;
        while (dut.direction === 1'b0 && len < 200) begin
            if (val_tri !== 1'b1) bad++;
            tick();
            len++;
        end
        chk_val("drive_len", len, PULSE_LEN);
        chk_val("drive_pad", bad, 0);
        chk_val("busy_turn", busy, 1);
        if (hold) drv = 1'b1;
        l0 = exp_start + PULSE_LEN + TURNAROUND;
        while (busy === 1'b1 && cyc < l0 + TIMEOUT + 8) begin
            if (k >= 0 && cyc == l0 + k) drv = 1'b1;
            alarm_clear = clr_end && (cyc == l0 + TIMEOUT - 1);
            tick();
        end
        alarm_clear = 1'b0;
        hit = (k >= 0) && !hold && (k + 2 <= TIMEOUT - 1);
        exp_end = hit ? l0 + k + 3 : l0 + TIMEOUT;
        chk_val("end_cycle", cyc, exp_end);
        chk_val("resp_valid", resp_valid, int'(hit));
        if (hit) begin
            m_miss = 0;
        end else begin
            if (clr_end) m_alarm = 0;
            m_miss = (m_miss < 255) ? m_miss + 1 : 255;
            if (m_miss >= MAX_MISS) m_alarm = 1;
        end
        chk_val("miss_count", miss_count, m_miss);
        chk_val("alarm", alarm, m_alarm);
        drv = 1'b0;
        tick();
        chk_val("resp_pulse", resp_valid, 0);
        next_start = exp_end + ((next_period == 0) ? 1 : next_period);
    endtask

    task automatic clear_alarm();
        alarm_clear = 1'b1;
        tick();
        alarm_clear = 1'b0;
        m_alarm = 0;
        m_miss = 0;
        chk_val("clr_alarm", alarm, m_alarm);
        chk_val("clr_miss", miss_count, m_miss);
    endtask

    initial begin
        int ns;
        int sel;
        int k;
        int np;
        repeat (2) tick();
        chk_val("rst_dir", dut.direction, 1);
        chk_val("rst_pad", val_tri, 0);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_resp", resp_valid, 0);
        chk_val("rst_miss", miss_count, 0);
        chk_val("rst_alarm", alarm, 0);

        rst = 1'b0;
        period = 32'd10;
        enable = 1'b1;
        ns = cyc + 1 + 10;
        ping(ns, 5, 1'b0, 1'b0, 8, ns);

        // Silence: misses 1, 2, 3 with alarm on the third; a response keeps the alarm.
        repeat (3) ping(ns, -1, 1'b0, 1'b0, 8, ns);
        ping(ns, 7, 1'b0, 1'b0, 8, ns);
        clear_alarm();
        ns = ns;
        ping(ns, -1, 1'b0, 1'b0, 8, ns);
        ping(ns, -1, 1'b0, 1'b0, 8, ns);
        ping(ns, -1, 1'b0, 1'b1, 8, ns);
        clear_alarm();

        ping(ns, -1, 1'b1, 1'b0, 8, ns);
        ping(ns, TIMEOUT - 3, 1'b0, 1'b0, 8, ns);
        ping(ns, TIMEOUT - 2, 1'b0, 1'b0, 8, ns);

        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 3);
            np = $urandom_range(0, 6);
            case (sel)
                0: ping(ns, $urandom_range(0, TIMEOUT - 3), 1'b0, 1'b0, np, ns);
                1: ping(ns, -1, 1'b0, 1'b0, np, ns);
                2: begin
                    k = TIMEOUT - 3 + $urandom_range(0, 2);
                    ping(ns, k, 1'b0, 1'b0, np, ns);
                end
                default: ping(ns, -1, 1'b1, 1'b0, np, ns);
            endcase
        end
        ping(ns, -1, 1'b0, 1'b0, 6, ns);

        // enable dropped mid-DRIVE: pad released next cycle, counters kept.
        wait_drive();
        repeat (3) tick();
        enable = 1'b0;
        tick();
        chk_val("en_dir", dut.direction, 1);
        chk_val("en_pad", val_tri, 0);
        chk_val("en_busy", busy, 0);
        chk_val("en_miss", miss_count, m_miss);
        chk_val("en_alarm", alarm, m_alarm);
        enable = 1'b1;
        tick();
        ns = cyc + 6;
        ping(ns, -1, 1'b0, 1'b0, 6, ns);

        // rst mid-DRIVE: pad released before any clock edge.
        wait_drive();
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk_val("arst_dir", dut.direction, 1);
        chk_val("arst_pad", val_tri, 0);
        chk_val("arst_busy", busy, 0);
        chk_val("arst_miss", miss_count, 0);
        chk_val("arst_alarm", alarm, 0);
        m_miss = 0;
        m_alarm = 0;
        #1 rst = 1'b0;
        tick();
        ns = cyc + 6;
        ping(ns, 4, 1'b0, 1'b0, 0, ns);

        // Continued silence saturates the miss counter.
        for (int i = 0; i < 257; i++) ping(ns, -1, 1'b0, 1'b0, 0, ns);
        chk_val("miss_sat", miss_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rp_ping_link_ctrl.md
RP_PING_LINK_CTRL -- requirements
Module: rp_ping_link_ctrl

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 16, meaning cycles the pad is driven high per ping.
REQ-002 SHALL have parameter TURNAROUND, default 4, meaning cycles the pad is released with input ignored after a ping.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning max LISTEN cycles before a miss.
REQ-004 SHALL have parameter MAX_MISS, default 3, meaning consecutive misses that raise alarm.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  in  1  run ping sequence while high.
REQ-008 SHALL have port period  in  32  idle cycles between end of one ping cycle and next DRIVE.
REQ-009 SHALL have port alarm_clear  in  1  one-cycle pulse; clears alarm and miss_count.
REQ-010 SHALL have port val_tri  inout  1  shared single-wire pad.
REQ-011 SHALL have port busy  out  1  high in DRIVE, TURN, LISTEN.
REQ-012 SHALL have port resp_valid  out  1  one-cycle pulse on accepted response.
REQ-013 SHALL have port miss_count  out  8  consecutive misses, saturating at 255.
REQ-014 SHALL have port alarm  out  1  sticky link-failure flag.

Function
REQ-015 SHALL implement states IDLE, WAIT, DRIVE, TURN, LISTEN.
REQ-016 IDLE: pad released (direction=1); enable high -> WAIT with wait counter loaded.
REQ-017 WAIT: pad released; counts period cycles (period=0 treated as 1) -> DRIVE.
REQ-018 DRIVE: direction=0, val_out=1 for exactly PULSE_LEN cycles -> TURN.
REQ-019 TURN: direction=1, val_out=0, synchronised input ignored for TURNAROUND cycles -> LISTEN.
REQ-020 LISTEN: response is a 0->1 transition of the 2-flop-synchronised pad input, detected with one extra register (pad edge to resp_valid: 3 cycles).
REQ-021 LISTEN: line already high on entry gives no edge; only a fresh rising edge counts.
REQ-022 On response: resp_valid=1 for one cycle, miss_count=0, -> WAIT.
REQ-023 After TIMEOUT LISTEN cycles without response: miss_count increments (saturating at 255) -> WAIT.
REQ-024 alarm SHALL set when miss_count reaches MAX_MISS and stay set until alarm_clear or rst.
REQ-025 A response clears miss_count but SHALL NOT clear alarm.
REQ-026 alarm_clear in the same cycle as an alarm-setting miss: set wins; miss_count takes incremented value.
REQ-027 enable low in any state: next cycle -> IDLE, pad released, counters reset; alarm and miss_count retained.
REQ-028 Response edge and timeout expiry in the same cycle: response wins.
REQ-029 Pad SHALL never be driven outside DRIVE; direction SHALL be 1 whenever val_out could be 1 outside DRIVE.

Reset
REQ-030 On rst: state IDLE, direction=1, val_out=0, busy=0, resp_valid=0, miss_count=0, alarm=0, synchroniser flops 0.
REQ-031 rst asserted mid-DRIVE SHALL release the pad asynchronously, without waiting for a clock edge.

Structure
REQ-032 State encoding and miss-counter width SHALL live in shared package rp_ping_pkg.
REQ-033 The pad SHALL be one instance of the existing rp_iobuf wrapper (IOBUF plus 2-flop input synchroniser); no other sub-module.

Verification
REQ-034 enable=1, period=10, pull-up responder answers 5 cycles into LISTEN: 16-cycle drive, 4-cycle release, resp_valid 3 cycles after pad edge, miss_count=0.
REQ-035 No responder, MAX_MISS=3: miss_count 1,2,3 after three TIMEOUT windows; alarm rises with third miss; miss_count saturates at 255 on continued silence.
REQ-036 Responder drives high during TURN and holds high: no resp_valid; miss counted.
REQ-037 alarm_clear coincident with third miss: alarm=1 after edge; a later alarm_clear alone: alarm=0, miss_count=0.
REQ-038 rst (or enable=0) asserted mid-DRIVE: pad tri-stated immediately for rst, next cycle for enable=0; restart begins from WAIT.
